// File: rtl/fir_mac_scheduler.sv
// Time-multiplexed FIR sequencer: one shared multiplier, sample delay line,
// synchronous coefficient ROM addressing, accumulate, saturate, emit.
module fir_mac_scheduler #(
    parameter int TAPS = 16,
    parameter int AW   = 4,
    parameter int ACCW = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sample_valid,
    input  logic [15:0]   sample_in,
    output logic          busy,
    output logic [AW-1:0] coef_addr,
    input  logic [15:0]   coef_data,
    output logic [15:0]   mult_a,
    output logic [15:0]   mult_b,
    input  logic [15:0]   mult_p,
    output logic [15:0]   y_out,
    output logic          y_valid,
    output logic          overrun
);

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        MAC,
        DONE
    } state_t;

    state_t            state_q;
    logic [15:0]       dline_q [TAPS];
    logic [AW-1:0]     wptr_q;
    logic [AW-1:0]     k_q;
    logic [ACCW-1:0]   acc_q;
    logic [15:0]       sreg_q;
    logic [AW-1:0]     coef_addr_q;
    logic [15:0]       y_out_q;
    logic              y_valid_q;
    logic              overrun_q;

    logic [ACCW-1:0]   acc_d;
    logic [ACCW-16:0]  acc_hi;
    logic [15:0]       sat_d;
    logic [AW-1:0]     wr_idx;
    logic [AW-1:0]     rd_idx;

    // Final tap sum is saturated in the same cycle so y_valid lands on DONE.
    always_comb begin
        acc_d  = acc_q + {{(ACCW-16){mult_p[15]}}, mult_p};
        acc_hi = acc_d[ACCW-1:15];
        if ((&acc_hi) || !(|acc_hi)) begin
            sat_d = acc_d[15:0];
        end else if (acc_d[ACCW-1]) begin
            sat_d = 16'h8000;
        end else begin
            sat_d = 16'h7FFF;
        end
        wr_idx = wptr_q + AW'(1);
        rd_idx = wptr_q - k_q - AW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            for (int i = 0; i < TAPS; i++) dline_q[i] <= '0;
            wptr_q      <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            sreg_q      <= '0;
            coef_addr_q <= '0;
            y_out_q     <= '0;
            y_valid_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            y_valid_q <= 1'b0;
            overrun_q <= sample_valid && (state_q != IDLE);
            unique case (state_q)
                IDLE: begin
                    if (sample_valid) begin
                        dline_q[wr_idx] <= sample_in;
                        wptr_q          <= wr_idx;
                        acc_q           <= '0;
                        k_q             <= '0;
                        coef_addr_q     <= '0;
                        state_q         <= PRIME;
                    end
                end
                PRIME: begin
                    sreg_q      <= dline_q[wptr_q];
                    coef_addr_q <= AW'(1);
                    state_q     <= MAC;
                end
                MAC: begin
                    acc_q       <= acc_d;
                    sreg_q      <= dline_q[rd_idx];
                    coef_addr_q <= k_q + AW'(2);
                    k_q         <= k_q + AW'(1);
                    if (k_q == AW'(TAPS - 1)) begin
                        y_out_q   <= sat_d;
                        y_valid_q <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state_q != IDLE);
    assign coef_addr = coef_addr_q;
    assign mult_a    = (state_q == MAC) ? sreg_q : 16'h0000;
    assign mult_b    = (state_q == MAC) ? coef_data : 16'h0000;
    assign y_out     = y_out_q;
    assign y_valid   = y_valid_q;
    assign overrun   = overrun_q;

endmodule
